// File: rtl/hls_sched_pkg.sv
// rtl/hls_sched_pkg.sv - opcodes, FSM states and instruction field helpers for hls_sched_core
package hls_sched_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_SEL  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  typedef enum logic [1:0] {IDLE, EXEC, MULW, FIN} state_t;

  // Instruction word is {op[2:0], dst, src1, src2}, each index ridx_w bits.
  function automatic int instr_w(input int ridx_w);
    return 3 + 3 * ridx_w;
  endfunction

  function automatic int op_lsb(input int ridx_w);
    return 3 * ridx_w;
  endfunction

  function automatic int dst_lsb(input int ridx_w);
    return 2 * ridx_w;
  endfunction

  function automatic int src1_lsb(input int ridx_w);
    return ridx_w;
  endfunction

  function automatic int src2_lsb(input int ridx_w);
    return 0 * ridx_w;
  endfunction

endpackage

// File: rtl/hls_sched_mul.sv
// rtl/hls_sched_mul.sv - LAT-stage pipelined multiplier with valid-in/valid-out
module hls_sched_mul #(
  parameter int WIDTH = 16,
  parameter int P_W   = 32,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [P_W-1:0]   p
);

  logic [P_W-1:0] ps [LAT];
  logic [LAT-1:0] vs;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vs <= '0;
    end else begin
      vs[0] <= in_valid;
      for (int i = 1; i < LAT; i++) vs[i] <= vs[i-1];
    end
  end

  always_ff @(posedge clk) begin
    ps[0] <= P_W'(a) * P_W'(b);
    for (int i = 1; i < LAT; i++) ps[i] <= ps[i-1];
  end

  assign out_valid = vs[LAT-1];
  assign p         = ps[LAT-1];

endmodule

// File: rtl/hls_sched_core.sv
// rtl/hls_sched_core.sv - micro-programmed register/ALU scheduler core
// HLS_SCHED_SAT_EN: saturating ADD/MUL plus sticky sat_flag output.
module hls_sched_core
  import hls_sched_pkg::*;
#(
  parameter int  WIDTH      = 16,
  parameter int  NREGS      = 8,
  parameter int  PROG_DEPTH = 16,
  parameter int  MUL_LAT    = 2,
  localparam int RIDX_W     = $clog2(NREGS),
  localparam int PA_W       = $clog2(PROG_DEPTH),
  localparam int INSTR_W    = instr_w(RIDX_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [PA_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               arg_we,
  input  logic [RIDX_W-1:0]  arg_idx,
  input  logic [WIDTH-1:0]   arg_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
`ifdef HLS_SCHED_SAT_EN
  output logic               sat_flag,
`endif
  input  logic [RIDX_W-1:0]  res_idx,
  output logic [WIDTH-1:0]   res_data
);

  localparam int OP_L = op_lsb(RIDX_W);
  localparam int DS_L = dst_lsb(RIDX_W);
  localparam int S1_L = src1_lsb(RIDX_W);
  localparam int S2_L = src2_lsb(RIDX_W);
  localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MUL_LAT - 1);
  localparam logic [PA_W-1:0] PC_LAST = PA_W'(PROG_DEPTH - 1);
`ifdef HLS_SCHED_SAT_EN
  localparam int P_W = 2 * WIDTH;
`else
  localparam int P_W = WIDTH;
`endif

  state_t               state, state_n;
  logic [PA_W-1:0]      pc, pc_n;
  logic [INSTR_W-1:0]   prog_mem [PROG_DEPTH];
  logic [WIDTH-1:0]     regs [NREGS];
  logic [MC_W-1:0]      mul_cnt;
  logic [INSTR_W-1:0]   instr;
  logic [2:0]           op;
  logic [RIDX_W-1:0]    dst, src1, src2;
  logic [WIDTH-1:0]     va, vb, vd, add_val, mul_val, wr_val;
  logic                 wr_en, mul_go, err_set, step, mul_ovalid;
  logic [P_W-1:0]       mul_p;

  assign instr = prog_mem[pc];
  assign op    = instr[OP_L +: 3];
  assign dst   = instr[DS_L +: RIDX_W];
  assign src1  = instr[S1_L +: RIDX_W];
  assign src2  = instr[S2_L +: RIDX_W];
  assign va    = regs[src1];
  assign vb    = regs[src2];
  assign vd    = regs[dst];
  assign busy  = (state == EXEC) || (state == MULW);
  assign done  = (state == FIN);

`ifdef HLS_SCHED_SAT_EN
  logic [WIDTH:0] sum;
  logic           add_ovf, mul_ovf, sat_set;
  assign sum     = {1'b0, va} + {1'b0, vb};
  assign add_ovf = sum[WIDTH];
  assign add_val = add_ovf ? '1 : sum[WIDTH-1:0];
  assign mul_ovf = |mul_p[P_W-1:WIDTH];
  assign mul_val = mul_ovf ? '1 : mul_p[WIDTH-1:0];
  assign sat_set = (state == EXEC && op == OP_ADD && add_ovf) ||
                   (state == MULW && mul_cnt == MC_LAST && mul_ovf);
`else
  assign add_val = va + vb;
  assign mul_val = mul_p;
`endif

  hls_sched_mul #(.WIDTH(WIDTH), .P_W(P_W), .LAT(MUL_LAT)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mul_go),
    .a         (va),
    .b         (vb),
    .out_valid (mul_ovalid),
    .p         (mul_p)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    wr_en   = 1'b0;
    wr_val  = va;
    mul_go  = 1'b0;
    err_set = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = EXEC;
        pc_n    = '0;
      end
      EXEC: begin
        case (op)
          OP_NOP:  step = 1'b1;
          OP_MOV:  begin wr_en = 1'b1; wr_val = va; step = 1'b1; end
          OP_ADD:  begin wr_en = 1'b1; wr_val = add_val; step = 1'b1; end
          OP_SEL:  begin wr_en = 1'b1; wr_val = vd[0] ? vb : va; step = 1'b1; end
          OP_MUL:  begin mul_go = 1'b1; state_n = MULW; end
          OP_HALT: state_n = FIN;
          default: begin err_set = 1'b1; state_n = FIN; end
        endcase
      end
      MULW: if (mul_cnt == MC_LAST) begin
        wr_en   = 1'b1;
        wr_val  = mul_val;
        state_n = EXEC;
        step    = 1'b1;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // The last program slot ends the run rather than letting pc wrap.
    if (step) begin
      if (pc == PC_LAST) state_n = FIN;
      else               pc_n    = pc + PA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= '0;
      err      <= 1'b0;
      mul_cnt  <= '0;
      res_data <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      pc      <= pc_n;
      mul_cnt <= (state == MULW) ? mul_cnt + MC_W'(1) : '0;
      if (state == IDLE && start) err <= 1'b0;
      else if (err_set)           err <= 1'b1;
      if (arg_we && !busy) regs[arg_idx] <= arg_data;
      if (wr_en)           regs[dst]     <= wr_val;
      res_data <= regs[res_idx];
    end
  end

`ifdef HLS_SCHED_SAT_EN
  always_ff @(posedge clk) begin
    if (!reset)                 sat_flag <= 1'b0;
    else if (state == IDLE && start) sat_flag <= 1'b0;
    else if (sat_set)           sat_flag <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (prog_we && !busy) prog_mem[prog_addr] <= prog_data;
  end

  mulw_align: assert property (@(posedge clk) disable iff (!reset)
    mul_ovalid == (state == MULW && mul_cnt == MC_LAST));

endmodule

// File: doc/hls_sched_core.md
Name: hls_sched_core

Overview:
- Parametrised successor to the generated register/adder/multiplier/mux/FSM datapath.
- The generated design hard-codes its schedule into FSM case arms. This block instead executes a loadable micro-program over a register file with a shared adder, a pipelined multiplier and a 2:1 select unit.
- It sits under the generated top as the reusable compute core. The host loads the program and arguments, pulses start, waits for done, then reads results.

Parameters:
- WIDTH, 16: datapath and register width in bits.
- NREGS, 8: register-file entries; power of two, at least 2.
- PROG_DEPTH, 16: micro-program memory depth in instructions; power of two.
- MUL_LAT, 2: multiplier pipeline latency in cycles, at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- prog_we  in  1  program memory write strobe.
- prog_addr  in  PA_W = clog2(PROG_DEPTH)  program write address.
- prog_data  in  INSTR_W = 3 + 3*RIDX_W  instruction word {op[2:0], dst, src1, src2}; RIDX_W = clog2(NREGS).
- arg_we  in  1  register-file host write strobe.
- arg_idx  in  RIDX_W  register written by arg_we.
- arg_data  in  WIDTH  argument value.
- start  in  1  run request.
- busy  out  1  high while executing.
- done  out  1  one-cycle pulse on completion.
- err  out  1  sticky illegal-opcode flag; cleared by start.
- res_idx  in  RIDX_W  register read index.
- res_data  out  WIDTH  r[res_idx], registered, 1-cycle latency.

Behaviour:
- Clock and reset:
  - Single clock clk; reset synchronous, active-low.
  - On reset: state=IDLE, pc=0, all r[i]=0, busy=0, done=0, err=0, res_data=0.
  - Program memory is not reset; its contents survive reset.
  - Reset mid-run aborts immediately; no done pulse.
- Opcodes:
  - 0 NOP.
  - 1 MOV: r[dst] <= r[src1].
  - 2 ADD: r[dst] <= (r[src1] + r[src2]) mod 2^WIDTH.
  - 3 MUL: r[dst] <= low WIDTH bits of r[src1]*r[src2].
  - 4 SEL: r[dst] <= r[dst][0] ? r[src2] : r[src1]. The select bit is sampled from the old r[dst].
  - 5 HALT.
  - 6 and 7 are illegal: behave as HALT and set err.
- FSM states IDLE, EXEC, MULW, FIN:
  - IDLE: when start=1, go to EXEC with pc=0 and err cleared; busy rises the next cycle.
  - EXEC: one instruction per cycle. Register write and pc+1 occur at the clock edge of execution; a following instruction sees the new value.
  - EXEC, MUL: operands are captured and the FSM enters MULW, stalling exactly MUL_LAT cycles. The result is written on the final MULW cycle, then pc+1 and return to EXEC. Total MUL cost is 1+MUL_LAT cycles.
  - EXEC, HALT, illegal opcode, or a non-HALT instruction executed at pc=PROG_DEPTH-1: go to FIN. pc never wraps.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- busy is 1 in EXEC and MULW only.
- Host accesses:
  - start is ignored unless in IDLE.
  - prog_we and arg_we are ignored while busy; they are accepted in IDLE and FIN.
  - arg_we in the same cycle as start: the write lands first and is visible to instruction 0.
  - res_data is valid in any state; reading during a run returns in-flight values.
- Timing: latency from start to done is 2 + Σ(instruction cycles).
- dst=src is legal. Read-before-write applies within an instruction.

Optional Feature:
- Macro: HLS_SCHED_SAT_EN.
- Defined: ADD and MUL saturate to 2^WIDTH-1 on unsigned overflow instead of wrapping. A sticky output sat_flag (1 bit, reset 0, cleared by start) sets on any saturation event.
- Undefined: ADD and MUL wrap modulo 2^WIDTH, and there is no sat_flag port.

Decomposition:
- Package hls_sched_pkg holds:
  - Opcode localparams OP_NOP..OP_HALT.
  - FSM state encoding.
  - An INSTR_W helper function.
  - Field-slice constants for op, dst, src1 and src2.
- One sub-module: hls_sched_mul, a MUL_LAT-stage pipelined multiplier with valid-in/valid-out. The core checks that valid-out aligns with the final MULW cycle.

Test Plan:
- Basic ALU: load r1=3, r2=5. Program: ADD r3,r1,r2; MUL r4,r3,r2; HALT. Pulse start → done after 2+1+(1+MUL_LAT)+1 cycles; r3=8, r4=40; err=0.
- Mux and wrap (WIDTH=16): r0=1, r1=0xFFFF, r2=2. Program: ADD r5,r1,r2; SEL r0,r1,r2; HALT → r5=0x0001; r0=2.
  - With HLS_SCHED_SAT_EN: r5=0xFFFF and sat_flag=1.
- End of memory: program of 16 NOPs with no HALT → done after 18 cycles; pc does not wrap.
- Illegal opcode: opcode 7 at pc=2 → done pulse, err=1. A following start clears err.
- Host collisions: start while busy is ignored; prog_we and arg_we while busy leave memory and registers unchanged. arg_we r1=9 together with start, program MOV r2,r1 → r2=9.
- Reset mid-MULW: reset low for 1 cycle → busy=0, no done, all registers 0. The program is retained, and a rerun produces the correct results.
